// File: rtl/fpdiv_pkg.sv
// Shared types and constants for the Goldschmidt divider sequencer.
// State encoding, mux select codes and the per-state control decode.
package fpdiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IA_N,
        ST_IA_D,
        ST_IT_N,
        ST_IT_D,
        ST_REM,
        ST_DONE
    } fpdiv_state_t;

    localparam logic [1:0] MUX3_IA  = 2'b00;
    localparam logic [1:0] MUX3_C   = 2'b01;
    localparam logic [1:0] MUX3_REM = 2'b10;

    localparam logic [1:0] MUX4_N0 = 2'b00;
    localparam logic [1:0] MUX4_D0 = 2'b01;
    localparam logic [1:0] MUX4_NR = 2'b10;
    localparam logic [1:0] MUX4_DR = 2'b11;

    localparam int FPDIV_MAX_ITER = 15;

    typedef struct packed {
        logic       en_a;
        logic       en_b;
        logic       en_rem;
        logic [1:0] sel_mux3;
        logic [1:0] sel_mux4;
        logic       busy;
        logic       done;
    } fpdiv_ctrl_t;

    // Control word seen by the datapath while the FSM sits in state s.
    function automatic fpdiv_ctrl_t fpdiv_decode(input fpdiv_state_t s);
        fpdiv_ctrl_t c;
        c = '0;
        case (s)
            ST_IA_N: begin
                c.en_a = 1'b1; c.sel_mux4 = MUX4_N0; c.sel_mux3 = MUX3_IA; c.busy = 1'b1;
            end
            ST_IA_D: begin
                c.en_b = 1'b1; c.sel_mux4 = MUX4_D0; c.sel_mux3 = MUX3_IA; c.busy = 1'b1;
            end
            ST_IT_N: begin
                c.en_a = 1'b1; c.sel_mux4 = MUX4_NR; c.sel_mux3 = MUX3_C; c.busy = 1'b1;
            end
            ST_IT_D: begin
                c.en_b = 1'b1; c.sel_mux4 = MUX4_DR; c.sel_mux3 = MUX3_C; c.busy = 1'b1;
            end
            ST_REM: begin
                c.en_rem = 1'b1; c.sel_mux4 = MUX4_NR; c.sel_mux3 = MUX3_REM; c.busy = 1'b1;
            end
            ST_DONE: c.done = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fpdiv_ctrl.sv
// Moore sequencer for the fpdiv datapath: IA pair, NUM_ITER refinement pairs, REM, DONE.
// Optional FPDIV_CTRL_ABORT_EN adds an abort input that cancels a running operation.
module fpdiv_ctrl
    import fpdiv_pkg::*;
#(
    parameter int NUM_ITER = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rm_in,
`ifdef FPDIV_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic       rm,
    output logic       en_a,
    output logic       en_b,
    output logic       en_rem,
    output logic [1:0] sel_mux3,
    output logic [1:0] sel_mux4,
    output logic       busy,
    output logic       done
);

    generate
        if (NUM_ITER < 1 || NUM_ITER > FPDIV_MAX_ITER) begin : g_bad_iter
            $error("fpdiv_ctrl: NUM_ITER must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] ITER_LAST = 4'(NUM_ITER);

    fpdiv_state_t state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         rm_q, rm_d;
    fpdiv_ctrl_t  ctrl_q, ctrl_d;
    logic         cancel;

`ifdef FPDIV_CTRL_ABORT_EN
    assign cancel = abort && (state_q != ST_IDLE) && (state_q != ST_DONE);
`else
    assign cancel = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rm_d    = rm_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_IA_N;
                    rm_d    = rm_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IA_N: state_d = ST_IA_D;
            ST_IA_D: begin
                state_d = ST_IT_N;
                cnt_d   = 4'd1;
            end
            ST_IT_N: state_d = ST_IT_D;
            ST_IT_D: begin
                if (cnt_q == ITER_LAST) begin
                    state_d = ST_REM;
                end else begin
                    state_d = ST_IT_N;
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            ST_REM:  state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
        if (cancel) begin
            state_d = ST_IDLE;
        end
        // Outputs are registered alongside the state so they decode the state being entered.
        ctrl_d = fpdiv_decode(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rm_q    <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rm_q    <= rm_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign rm       = rm_q;
    assign en_a     = ctrl_q.en_a;
    assign en_b     = ctrl_q.en_b;
    assign en_rem   = ctrl_q.en_rem;
    assign sel_mux3 = ctrl_q.sel_mux3;
    assign sel_mux4 = ctrl_q.sel_mux4;
    assign busy     = ctrl_q.busy;
    assign done     = ctrl_q.done;

endmodule
